acc_flag_timer_mc: RTL and testbench

//  Multi-channel successor to the single-channel accumulation-flag timer. Each of CH_NUM channels

---
 rtl/acc_flag_timer_mc.sv | 165 ++++++++++++++++
 tb/tb_acc_flag_timer_mc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_flag_timer_mc.sv
// Multi-channel accumulation-flag timer: each channel qualifies its accumulation result into a
// flag with a tick-counted assert delay, deassert delay and hold, plus OR/count summaries.
module acc_flag_timer_mc #(
    parameter int CH_NUM = 4,
    parameter int CNT_W  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          unit_tick_i,
    input  logic [CH_NUM-1:0]             ch_en_i,
    input  logic                          glitch_rej_i,
    input  logic [CH_NUM-1:0]             acc_result_i,
    input  logic [CNT_W-1:0]              acc_delay_i,
    input  logic [CNT_W-1:0]              acc_hold_i,
    output logic [CH_NUM-1:0]             acc_flag_o,
    output logic                          acc_flag_any_o,
    output logic [$clog2(CH_NUM+1)-1:0]   acc_flag_cnt_o
);

    localparam int CW = $clog2(CH_NUM + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADLY,
        S_ACTIVE,
        S_DDLY,
        S_HOLD
    } state_t;

    state_t            state_q  [CH_NUM];
    state_t            state_nx [CH_NUM];
    logic [CNT_W-1:0]  cnt_q    [CH_NUM];
    logic [CNT_W-1:0]  cnt_nx   [CH_NUM];
    logic [CNT_W:0]    inc      [CH_NUM];
    logic [CNT_W-1:0]  cnt_sat  [CH_NUM];
    logic [CH_NUM-1:0] res_d;
    logic [CH_NUM-1:0] rise;
    logic [CH_NUM-1:0] fall;
    logic [CH_NUM-1:0] flag_nx;
    logic [CNT_W-1:0]  dly_eff;
    logic [CNT_W:0]    dly_lim;
    logic [CNT_W:0]    hold_lim;
    logic [CW-1:0]     cnt_sum;

    assign rise     = acc_result_i & ~res_d;
    assign fall     = ~acc_result_i & res_d;
    assign dly_eff  = (acc_delay_i == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : acc_delay_i;
    // One extra bit on the compare operands so cnt+1 can never wrap past the limit.
    assign dly_lim  = {1'b0, dly_eff};
    assign hold_lim = {1'b0, acc_hold_i};

    always_comb begin
        for (int n = 0; n < CH_NUM; n++) begin
            inc[n]      = {1'b0, cnt_q[n]} + {{CNT_W{1'b0}}, 1'b1};
            cnt_sat[n]  = inc[n][CNT_W] ? cnt_q[n] : inc[n][CNT_W-1:0];
            state_nx[n] = state_q[n];
            cnt_nx[n]   = cnt_q[n];
            flag_nx[n]  = acc_flag_o[n];
            case (state_q[n])
                S_IDLE: begin
                    flag_nx[n] = 1'b0;
                    if (rise[n]) begin
                        state_nx[n] = S_ADLY;
                        cnt_nx[n]   = '0;
                    end
                end
                S_ADLY: begin
                    if (fall[n] && glitch_rej_i) begin
                        state_nx[n] = S_IDLE;
                        cnt_nx[n]   = '0;
                        flag_nx[n]  = 1'b0;
                    end else if (unit_tick_i) begin
                        if (inc[n] >= dly_lim) begin
                            // A result that dropped during the delay goes straight into deassert.
                            state_nx[n] = acc_result_i[n] ? S_ACTIVE : S_DDLY;
                            cnt_nx[n]   = '0;
                            flag_nx[n]  = 1'b1;
                        end else begin
                            cnt_nx[n] = cnt_sat[n];
                        end
                    end
                end
                S_ACTIVE: begin
                    flag_nx[n] = 1'b1;
                    if (fall[n]) begin
                        state_nx[n] = S_DDLY;
                        cnt_nx[n]   = '0;
                    end
                end
                S_DDLY: begin
                    if (rise[n]) begin
                        state_nx[n] = S_ACTIVE;
                        cnt_nx[n]   = '0;
                    end else if (unit_tick_i) begin
                        if (inc[n] >= dly_lim) begin
                            cnt_nx[n] = '0;
                            if (acc_hold_i == '0) begin
                                state_nx[n] = S_IDLE;
                                flag_nx[n]  = 1'b0;
                            end else begin
                                state_nx[n] = S_HOLD;
                            end
                        end else begin
                            cnt_nx[n] = cnt_sat[n];
                        end
                    end
                end
                S_HOLD: begin
                    if (rise[n]) begin
                        state_nx[n] = S_ACTIVE;
                        cnt_nx[n]   = '0;
                    end else if (unit_tick_i) begin
                        if (inc[n] >= hold_lim) begin
                            state_nx[n] = S_IDLE;
                            cnt_nx[n]   = '0;
                            flag_nx[n]  = 1'b0;
                        end else begin
                            cnt_nx[n] = cnt_sat[n];
                        end
                    end
                end
                default: begin
                    state_nx[n] = S_IDLE;
                    cnt_nx[n]   = '0;
                    flag_nx[n]  = 1'b0;
                end
            endcase
            if (!ch_en_i[n]) begin
                state_nx[n] = S_IDLE;
                cnt_nx[n]   = '0;
                flag_nx[n]  = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_sum = '0;
        for (int n = 0; n < CH_NUM; n++) begin
            cnt_sum = cnt_sum + CW'(flag_nx[n]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_d          <= '0;
            acc_flag_o     <= '0;
            acc_flag_any_o <= 1'b0;
            acc_flag_cnt_o <= '0;
            for (int n = 0; n < CH_NUM; n++) begin
                state_q[n] <= S_IDLE;
                cnt_q[n]   <= '0;
            end
        end else begin
            res_d          <= acc_result_i;
            acc_flag_o     <= flag_nx;
            acc_flag_any_o <= |flag_nx;
            acc_flag_cnt_o <= cnt_sum;
            for (int n = 0; n < CH_NUM; n++) begin
                state_q[n] <= state_nx[n];
                cnt_q[n]   <= cnt_nx[n];
            end
        end
    end

endmodule

// File: tb/tb_acc_flag_timer_mc.sv
// Bench for acc_flag_timer_mc: directed stimulus pushes the expected output change (cycle + value)
// into a queue; a monitor pops and compares each time the outputs change.
module tb_acc_flag_timer_mc;

    localparam int CH_NUM = 4;
    localparam int CNT_W  = 16;
    localparam int W      = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              unit_tick = 1'b1;
    logic [CH_NUM-1:0] ch_en = 4'hF;
    logic              glitch_rej = 1'b0;
    logic [CH_NUM-1:0] acc_result = '0;
    logic [CNT_W-1:0]  acc_delay = 16'd3;
    logic [CNT_W-1:0]  acc_hold = 16'd2;
    logic [CH_NUM-1:0] acc_flag;
    logic              acc_flag_any;
    logic [2:0]        acc_flag_cnt;

    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           t;

    acc_flag_timer_mc #(.CH_NUM(CH_NUM), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .unit_tick_i    (unit_tick),
        .ch_en_i        (ch_en),
        .glitch_rej_i   (glitch_rej),
        .acc_result_i   (acc_result),
        .acc_delay_i    (acc_delay),
        .acc_hold_i     (acc_hold),
        .acc_flag_o     (acc_flag),
        .acc_flag_any_o (acc_flag_any),
        .acc_flag_cnt_o (acc_flag_cnt)
    );

    // Clock and cycle index: cyc equals the number of rising edges seen so far.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input logic [3:0] f);
        logic [2:0] k;
        k = 3'($countones(f));
        exp_q.push_back({32'(c), f, |f, k});
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every change of {flag, any, cnt} must match the next queued expectation.
    logic [7:0] prev = '0;
    logic [7:0] cur;
    logic [W-1:0] e;
    always @(negedge clk) begin
        if (rst) begin
            prev = '0;
        end else begin
            cur = {acc_flag, acc_flag_any, acc_flag_cnt};
            if (cur !== prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_change: cyc=%0d got %h expected no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e !== {32'(cyc), cur}) begin
                        n_err++;
                        $display("FAIL out_change: got cyc=%0d val=%h expected cyc=%0d val=%h",
                                 cyc, cur, e[39:8], e[7:0]);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        // Reset state
        step(3);
        check("reset_hold", {acc_flag, acc_flag_any, acc_flag_cnt}, 8'h00);
        rst = 1'b0;
        step(2);
        check("reset_release", {acc_flag, acc_flag_any, acc_flag_cnt}, 8'h00);

        // Basic assert/deassert: delay 3, hold 2, result high 10 clocks
        acc_delay = 16'd3; acc_hold = 16'd2; unit_tick = 1'b1;
        t = cyc;
        acc_result = 4'b0001;
        expect_at(t + 4, 4'b0001);
        expect_at(t + 16, 4'b0000);
        step(10);
        acc_result = 4'b0000;
        step(20);

        // Sparse ticks on ch1: delay 2, no hold, tick every 4th clock
        acc_delay = 16'd2; acc_hold = 16'd0;
        t = cyc;
        expect_at(t + 7, 4'b0010);
        expect_at(t + 27, 4'b0000);
        for (int i = 0; i < 40; i++) begin
            unit_tick = ((i % 4) == 2);
            if (i == 0) acc_result = 4'b0010;
            if (i == 20) acc_result = 4'b0000;
            step(1);
        end
        unit_tick = 1'b1;
        step(5);

        // Glitch rejection: 2-clock pulse with delay 5 is dropped
        acc_delay = 16'd5; acc_hold = 16'd2; glitch_rej = 1'b1;
        acc_result = 4'b0001;
        step(2);
        acc_result = 4'b0000;
        step(15);

        // Same pulse without rejection: assert after 5, then 5 + hold to release
        glitch_rej = 1'b0;
        t = cyc;
        expect_at(t + 6, 4'b0001);
        expect_at(t + 13, 4'b0000);
        acc_result = 4'b0001;
        step(2);
        acc_result = 4'b0000;
        step(20);

        // Retrigger during hold keeps the flag, next fall restarts delay + hold
        acc_delay = 16'd3; acc_hold = 16'd4;
        t = cyc;
        expect_at(t + 4, 4'b0001);
        expect_at(t + 23, 4'b0000);
        acc_result = 4'b0001;
        step(6);
        acc_result = 4'b0000;
        step(5);
        acc_result = 4'b0001;
        step(4);
        acc_result = 4'b0000;
        step(30);

        // Zero delay and zero hold: one tick each way
        acc_delay = 16'd0; acc_hold = 16'd0;
        t = cyc;
        expect_at(t + 2, 4'b0001);
        expect_at(t + 7, 4'b0000);
        acc_result = 4'b0001;
        step(5);
        acc_result = 4'b0000;
        step(10);

        // Lowering the delay mid-phase ends it on the next tick; disable clears the flag
        acc_delay = 16'd10;
        t = cyc;
        expect_at(t + 4, 4'b0001);
        expect_at(t + 7, 4'b0000);
        acc_result = 4'b0001;
        step(3);
        acc_delay = 16'd2;
        step(3);
        ch_en = 4'b1110;
        step(1);
        acc_result = 4'b0000;
        ch_en = 4'hF;
        step(10);

        // Maximum delay asserts at tick 65535; re-enable with result high stays low
        acc_delay = 16'hFFFF; acc_hold = 16'd0;
        t = cyc;
        expect_at(t + 65536, 4'b0001);
        expect_at(t + 65541, 4'b0000);
        acc_result = 4'b0001;
        step(65540);
        ch_en = 4'b1110;
        step(1);
        ch_en = 4'hF;
        step(5);
        acc_result = 4'b0000;
        step(5);

        // All channels, ch2 disabled mid-active, then reset mid-hold
        acc_delay = 16'd2; acc_hold = 16'd3;
        t = cyc;
        expect_at(t + 3, 4'b1111);
        expect_at(t + 6, 4'b1011);
        acc_result = 4'b1111;
        step(5);
        ch_en = 4'b1011;
        step(2);
        ch_en = 4'hF;
        step(1);
        acc_result = 4'b0000;
        step(4);
        check("pre_reset_hold", {acc_flag, acc_flag_any, acc_flag_cnt}, {4'b1011, 1'b1, 3'd3});
        rst = 1'b1;
        #1;
        check("async_reset", {acc_flag, acc_flag_any, acc_flag_cnt}, 8'h00);
        step(2);
        rst = 1'b0;
        step(5);
        check("post_reset", {acc_flag, acc_flag_any, acc_flag_cnt}, 8'h00);

        // Any expectation never observed is a miss
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_change: got none expected cyc=%0d val=%h", e[39:8], e[7:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
